// File: rtl/riscv_types.sv
// Shared RISC-V core types: XLEN, register addresses, ALU operand bundle
// and the issue/writeback entry carried by the ALU issue arbiter.
package riscv_types;

    localparam int XLEN            = 32;
    localparam int ALU_ARB_MAX_REQ = 8;

    typedef logic [4:0] rs_addr_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLTU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_t;

    typedef struct packed {
        alu_op_t           op;
        logic [XLEN-1:0]   in1;
        logic [XLEN-1:0]   in2;
    } alu_inputs_t;

    // Wide enough for ALU_ARB_MAX_REQ sources.
    typedef logic [2:0] alu_arb_src_t;

    typedef struct packed {
        alu_inputs_t  inputs;
        logic         rd_en;
        rs_addr_t     rd_addr;
        alu_arb_src_t src;
    } alu_issue_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Request arbiter for the ALU issue slot.
// ALU_ARB_RR_EN: round-robin with pointer; otherwise fixed lowest-index priority.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    function automatic logic [NUM_REQ-1:0] first_one(
        input logic [NUM_REQ-1:0] v
    );
        return v & (~v + NUM_REQ'(1));
    endfunction

`ifdef ALU_ARB_RR_EN
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] above;
    logic [NUM_REQ-1:0] hi_req;

    // Requests strictly above the pointer win first; otherwise wrap to index 0.
    always_comb begin
        above = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above[i] = (i > int'(ptr_q));
        end
    end

    assign hi_req  = req_i & above;
    assign grant_o = (|hi_req) ? first_one(hi_req) : first_one(req_i);

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (advance_i && grant_o[i]) begin
                ptr_d = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_fixed;

    assign grant_o      = first_one(req_i);
    assign unused_fixed = ^{clk_i, rst_i, advance_i};
`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU among NUM_REQ issue sources: ISSUE then WB register.
// Define ALU_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module alu_issue_arbiter
    import riscv_types::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  alu_inputs_t [NUM_REQ-1:0]     req_inputs,
    input  logic [NUM_REQ-1:0]            req_rd_en,
    input  rs_addr_t [NUM_REQ-1:0]        req_rd_addr,
    input  logic [NUM_REQ-1:0][ID_W-1:0]  req_id,
    output alu_inputs_t                   alu_inputs,
    output logic                          alu_rd_en,
    output rs_addr_t                      alu_rd_addr,
    input  logic [XLEN-1:0]               alu_result,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic                          wb_rd_en,
    output rs_addr_t                      wb_rd_addr,
    output logic [XLEN-1:0]               wb_data,
    output logic [$clog2(NUM_REQ)-1:0]    wb_src,
    output logic [ID_W-1:0]               wb_id,
    output logic                          busy
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic               iss_v_q;
    logic               iss_v_d;
    alu_issue_t         iss_q;
    logic [ID_W-1:0]    iss_id_q;

    logic               wb_v_q;
    logic               wb_v_d;
    alu_issue_t         wb_q;
    logic [XLEN-1:0]    wb_data_q;
    logic [ID_W-1:0]    wb_id_q;

    logic               wb_adv;
    logic               iss_free;
    logic               hs;
    logic [NUM_REQ-1:0] grant;
    alu_issue_t         sel_op;
    logic [ID_W-1:0]    sel_id;
    logic               unused_wb;

    assign wb_adv   = iss_v_q & (~wb_v_q | wb_ready);
    assign iss_free = ~iss_v_q | wb_adv;

    alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_valid),
        .advance_i (hs),
        .grant_o   (grant)
    );

    assign req_ready = grant & {NUM_REQ{iss_free & ~rst}};
    assign hs        = |req_ready;

    always_comb begin
        sel_op = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op.inputs  = req_inputs[i];
                sel_op.rd_en   = req_rd_en[i];
                sel_op.rd_addr = req_rd_addr[i];
                sel_op.src     = alu_arb_src_t'(i);
                sel_id         = req_id[i];
            end
        end
    end

    // A reload wins over the drain so a full pipe keeps streaming.
    always_comb begin
        iss_v_d = iss_v_q;
        wb_v_d  = wb_v_q;
        if (hs) begin
            iss_v_d = 1'b1;
        end else if (wb_adv) begin
            iss_v_d = 1'b0;
        end
        if (wb_adv) begin
            wb_v_d = 1'b1;
        end else if (wb_ready) begin
            wb_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_v_q <= 1'b0;
            wb_v_q  <= 1'b0;
        end else begin
            iss_v_q <= iss_v_d;
            wb_v_q  <= wb_v_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            iss_q    <= sel_op;
            iss_id_q <= sel_id;
        end
        if (wb_adv) begin
            wb_q      <= iss_q;
            wb_data_q <= alu_result;
            wb_id_q   <= iss_id_q;
        end
    end

    assign alu_inputs  = iss_q.inputs;
    assign alu_rd_en   = iss_v_q & iss_q.rd_en;
    assign alu_rd_addr = iss_q.rd_addr;

    assign wb_valid    = wb_v_q;
    assign wb_rd_en    = wb_q.rd_en;
    assign wb_rd_addr  = wb_q.rd_addr;
    assign wb_data     = wb_data_q;
    assign wb_src      = wb_q.src[SRC_W-1:0];
    assign wb_id       = wb_id_q;
    assign busy        = iss_v_q | wb_v_q;

    assign unused_wb   = ^{wb_q.inputs, wb_q.src};

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter against a slot-level reference model.
module tb_alu_issue_arbiter;
    import riscv_types::*;

    localparam int N   = 2;
    localparam int IDW = 4;
    localparam int SW  = $clog2(N);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    alu_inputs_t [N-1:0]    req_inputs = '0;
    logic [N-1:0]           req_rd_en = '0;
    rs_addr_t [N-1:0]       req_rd_addr = '0;
    logic [N-1:0][IDW-1:0]  req_id = '0;
    alu_inputs_t            alu_inputs;
    logic                   alu_rd_en;
    rs_addr_t               alu_rd_addr;
    logic [XLEN-1:0]        alu_result;
    logic                   wb_valid;
    logic                   wb_ready = 1'b1;
    logic                   wb_rd_en;
    rs_addr_t               wb_rd_addr;
    logic [XLEN-1:0]        wb_data;
    logic [SW-1:0]          wb_src;
    logic [IDW-1:0]         wb_id;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    alu_issue_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_inputs  (req_inputs),
        .req_rd_en   (req_rd_en),
        .req_rd_addr (req_rd_addr),
        .req_id      (req_id),
        .alu_inputs  (alu_inputs),
        .alu_rd_en   (alu_rd_en),
        .alu_rd_addr (alu_rd_addr),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd_en    (wb_rd_en),
        .wb_rd_addr  (wb_rd_addr),
        .wb_data     (wb_data),
        .wb_src      (wb_src),
        .wb_id       (wb_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_ref(input alu_inputs_t x);
        logic [XLEN-1:0] r;
        case (x.op)
            ALU_ADD:  r = x.in1 + x.in2;
            ALU_SUB:  r = x.in1 - x.in2;
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, $signed(x.in1) < $signed(x.in2)};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, x.in1 < x.in2};
            ALU_AND:  r = x.in1 & x.in2;
            ALU_OR:   r = x.in1 | x.in2;
            ALU_XOR:  r = x.in1 ^ x.in2;
            ALU_SLL:  r = x.in1 << x.in2[4:0];
            ALU_SRL:  r = x.in1 >> x.in2[4:0];
            ALU_SRA:  r = $signed(x.in1) >>> x.in2[4:0];
            default:  r = '0;
        endcase
        return r;
    endfunction

    // The bench plays the role of the shared ALU.
    always_comb alu_result = alu_ref(alu_inputs);

    typedef struct {
        logic [XLEN-1:0] data;
        int              src;
        logic [IDW-1:0]  id;
        logic            rd_en;
        rs_addr_t        rd_addr;
    } op_t;

    op_t          m_iss;
    op_t          m_wb;
    bit           m_iss_v = 0;
    bit           m_wb_v  = 0;
    int           m_ptr   = N - 1;
    logic [N-1:0] exp_ready = '0;
    int           exp_g   = -1;

    function automatic int pick(input logic [N-1:0] v);
        int g;
        g = -1;
`ifdef ALU_ARB_RR_EN
        for (int k = N; k >= 1; k--) begin
            if (v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) g = k;
        end
`endif
        return g;
    endfunction

    task automatic sample();
        bit adv;
        bit free;
        @(negedge clk);
        adv   = m_iss_v && (!m_wb_v || wb_ready);
        free  = !m_iss_v || adv;
        exp_g = pick(req_valid);
        exp_ready = '0;
        if (exp_g >= 0 && free && !rst) exp_ready[exp_g] = 1'b1;
    endtask

    task automatic advance();
        bit adv;
        @(posedge clk);
        adv = m_iss_v && (!m_wb_v || wb_ready);
        if (rst) begin
            m_iss_v = 0;
            m_wb_v  = 0;
            m_ptr   = N - 1;
        end else begin
            if (adv) begin
                m_wb   = m_iss;
                m_wb_v = 1;
            end else if (wb_ready) begin
                m_wb_v = 0;
            end
            if (exp_ready != '0) begin
                m_iss.data    = alu_ref(req_inputs[exp_g]);
                m_iss.src     = exp_g;
                m_iss.id      = req_id[exp_g];
                m_iss.rd_en   = req_rd_en[exp_g];
                m_iss.rd_addr = req_rd_addr[exp_g];
                m_iss_v       = 1;
                m_ptr         = exp_g;
            end else if (adv) begin
                m_iss_v = 0;
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input alu_op_t op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [IDW-1:0] id, input rs_addr_t rd,
                           input logic en);
        req_inputs[i].op  = op;
        req_inputs[i].in1 = a;
        req_inputs[i].in2 = b;
        req_id[i]         = id;
        req_rd_addr[i]    = rd;
        req_rd_en[i]      = en;
    endtask

    task automatic rand_req(input int i);
        set_req(i, alu_op_t'(4'($urandom_range(0, 9))), $urandom, $urandom,
                IDW'($urandom), 5'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        sample();
        advance();
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) rand_req(i);
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (req_ready !== '0)
                $display("FAIL reset_ready c%0d got %b want 0", c, req_ready);
            if (req_ready !== '0) errors++;
            checks++;
            if ({busy, wb_valid, alu_rd_en} !== 3'b000) begin
                errors++;
                $display("FAIL reset_state busy/wbv/rden got %b want 000",
                         {busy, wb_valid, alu_rd_en});
            end
            advance();
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        wb_ready = 1'b1;
        set_req(0, ALU_ADD, 32'd5, 32'd7, 4'hA, 5'd3, 1'b1);
        req_valid = 2'b01;
        sample();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b want 01", req_ready);
        end
        advance();
        req_valid = '0;
        sample();
        checks++;
        if (alu_rd_en !== 1'b1 || alu_result !== 32'd12 || alu_rd_addr !== 5'd3
            || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_issue rden %b res %0d rd %0d wbv %b want 1 12 3 0",
                     alu_rd_en, alu_result, alu_rd_addr, wb_valid);
        end
        advance();
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'd12 || wb_src !== SW'(0)
            || wb_id !== 4'hA || wb_rd_addr !== 5'd3 || wb_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL single_wb v %b data %0d src %0d id %h want 1 12 0 a",
                     wb_valid, wb_data, wb_src, wb_id);
        end
        advance();
        sample();
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain wbv %b busy %b want 0 0", wb_valid, busy);
        end
        advance();
    endtask

    task automatic test_arb();
        logic [N-1:0] want;
        int           hist[$];
        do_reset();
        wb_ready = 1'b1;
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
`ifdef ALU_ARB_RR_EN
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            if (c == 4) req_valid[0] = 1'b0;
            want = (c < 4) ? 2'b01 : 2'b10;
`endif
            sample();
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL arb_grant c%0d got %b want %b", c, req_ready, want);
            end
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL arb_model c%0d got %b want %b", c, req_ready, exp_ready);
            end
            if (c >= 2) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_src !== SW'(hist[c-2])
                    || wb_data !== m_wb.data) begin
                    errors++;
                    $display("FAIL arb_wb c%0d v %b src %0d data %h want 1 %0d %h",
                             c, wb_valid, wb_src, wb_data, hist[c-2], m_wb.data);
                end
            end
            hist.push_back(want[1] ? 1 : 0);
            advance();
            for (int i = 0; i < N; i++) if (exp_ready[i]) rand_req(i);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        wb_ready = 1'b0;
        set_req(0, ALU_ADD, 32'd1, 32'd2, 4'h1, 5'd5, 1'b1);
        req_valid = 2'b01;
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL bp_fill c%0d got %b want 01", c, req_ready);
            end
            advance();
            set_req(0, c == 0 ? ALU_XOR : ALU_OR,
                    c == 0 ? 32'hF0 : 32'h100, c == 0 ? 32'h0F : 32'h001,
                    c == 0 ? 4'h2 : 4'h3, 5'd6, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (req_ready !== 2'b00 || wb_valid !== 1'b1 || wb_data !== 32'd3
                || wb_id !== 4'h1 || alu_result !== 32'hFF || alu_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c%0d rdy %b wbv %b data %h id %h alu %h",
                         c, req_ready, wb_valid, wb_data, wb_id, alu_result);
            end
            advance();
        end
        wb_ready = 1'b1;
        sample();
        checks++;
        if (req_ready !== 2'b01 || wb_valid !== 1'b1 || wb_data !== 32'd3) begin
            errors++;
            $display("FAIL bp_release rdy %b wbv %b data %h want 01 1 3",
                     req_ready, wb_valid, wb_data);
        end
        advance();
        req_valid = '0;
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hFF || wb_id !== 4'h2) begin
            errors++;
            $display("FAIL bp_second v %b data %h id %h want 1 ff 2",
                     wb_valid, wb_data, wb_id);
        end
        advance();
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h101 || wb_id !== 4'h3) begin
            errors++;
            $display("FAIL bp_third v %b data %h id %h want 1 101 3",
                     wb_valid, wb_data, wb_id);
        end
        advance();
        sample();
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty wbv %b busy %b want 0 0", wb_valid, busy);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_ready = 1'b0;
        set_req(0, ALU_ADD, 32'd10, 32'd20, 4'h4, 5'd7, 1'b1);
        set_req(1, ALU_SUB, 32'd9, 32'd4, 4'h5, 5'd8, 1'b1);
        req_valid = 2'b01;
        sample();
        advance();
        sample();
        advance();
        rst       = 1'b1;
        req_valid = 2'b11;
        sample();
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in rdy %b busy %b want 00 1", req_ready, busy);
        end
        advance();
        rst      = 1'b0;
        wb_ready = 1'b1;
        sample();
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_after wbv %b busy %b rdy %b want 0 0 01",
                     wb_valid, busy, req_ready);
        end
        advance();
        req_valid = '0;
        sample();
        checks++;
        if (wb_valid !== 1'b0 || alu_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stale wbv %b rden %b want 0 1", wb_valid, alu_rd_en);
        end
        advance();
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_src !== SW'(0) || wb_data !== 32'd30) begin
            errors++;
            $display("FAIL rstmid_first v %b src %0d data %0d want 1 0 30",
                     wb_valid, wb_src, wb_data);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] got[$];
        int              nacc;
        nacc = 0;
        do_reset();
        set_req(0, ALU_SUB, 32'd3, 32'd5, 4'h6, 5'd9, 1'b1);
        req_valid = 2'b01;
        for (int c = 0; c < 12; c++) begin
            wb_ready = (c % 3 != 1);
            sample();
            if (wb_valid === 1'b1 && wb_ready) got.push_back(wb_data);
            checks++;
            if (wb_valid !== m_wb_v || req_ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_step c%0d wbv %b rdy %b want %b %b",
                         c, wb_valid, req_ready, m_wb_v, exp_ready);
            end
            advance();
            if (exp_ready[0]) begin
                nacc++;
                if (nacc == 1) set_req(0, ALU_SLT, 32'd3, 32'd5, 4'h7, 5'd9, 1'b1);
                else req_valid = '0;
            end
        end
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d want 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 32'hFFFF_FFFE || got[1] !== 32'd1) begin
                errors++;
                $display("FAIL b2b_data got %h %h want fffffffe 00000001",
                         got[0], got[1]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || exp_ready[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    rand_req(i);
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            wb_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            sample();
            checks++;
            if (req_ready !== exp_ready || wb_valid !== m_wb_v
                || busy !== (m_iss_v || m_wb_v)
                || alu_rd_en !== (m_iss_v && m_iss.rd_en)) begin
                errors++;
                $display("FAIL rnd_ctrl c%0d rdy %b/%b wbv %b/%b busy %b rden %b",
                         c, req_ready, exp_ready, wb_valid, m_wb_v, busy, alu_rd_en);
            end
            if (m_wb_v) begin
                checks++;
                if (wb_data !== m_wb.data || wb_src !== SW'(m_wb.src)
                    || wb_id !== m_wb.id || wb_rd_en !== m_wb.rd_en
                    || wb_rd_addr !== m_wb.rd_addr) begin
                    errors++;
                    $display("FAIL rnd_wb c%0d data %h/%h src %0d/%0d id %h/%h",
                             c, wb_data, m_wb.data, wb_src, m_wb.src, wb_id, m_wb.id);
                end
            end
            advance();
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arb();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single-cycle combinational `alu` datapath between `NUM_REQ` issue sources, such as two dispatch queues or hart contexts.
- Arbitrates requests with a valid/ready handshake.
- Registers the granted operation into an issue stage that drives the ALU.
- Captures the ALU result into a backpressurable writeback register.
- Sits between dispatch and the register-file writeback port.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ID_W`, 4: width of the requester-supplied tag returned with each result.

Ports:
- `clk`  in  1  — single clock; every flop is rising-edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  [NUM_REQ]  — request present.
- `req_ready`  out  [NUM_REQ]  — request accepted this cycle; one-hot or zero.
- `req_inputs`  in  alu_inputs_t [NUM_REQ]  — operands and control per requester.
- `req_rd_en`  in  [NUM_REQ]  — operation writes rd.
- `req_rd_addr`  in  rs_addr_t [NUM_REQ]  — destination register.
- `req_id`  in  [NUM_REQ][ID_W]  — opaque tag.
- `alu_inputs`  out  alu_inputs_t  — issue-register contents, driven to the ALU.
- `alu_rd_en`  out  1  — issue valid AND issued rd_en.
- `alu_rd_addr`  out  rs_addr_t  — issued destination.
- `alu_result`  in  XLEN  — combinational ALU result for the issued operation.
- `wb_valid`  out  1  — writeback entry present.
- `wb_ready`  in  1  — consumer takes the entry.
- `wb_rd_en`, `wb_rd_addr`, `wb_data` (XLEN), `wb_src` ($clog2(NUM_REQ)), `wb_id` (ID_W)  out  — writeback payload.
- `busy`  out  1  — issue or writeback register occupied.

## Operation
- Two registered stages: ISSUE (`iss_v`) and WB (`wb_valid`). Each holds one operation.
- `wb_adv` = `iss_v` AND (NOT `wb_valid` OR `wb_ready`).
- `iss_free` = NOT `iss_v` OR `wb_adv`.
- Arbitration:
  - `grant` selects one asserted `req_valid`.
  - `req_ready[i]` = `grant[i]` AND `iss_free` AND NOT `rst`.
  - `req_ready` never depends on `wb_ready` except through `iss_free`.
- On a handshake, ISSUE loads `req_inputs`, `req_rd_en`, `req_rd_addr`, `req_id` and the source index, and sets `iss_v`.
- On `wb_adv`, WB loads `alu_result`, rd fields, src and id. ISSUE clears unless it is reloaded in the same cycle.
- `wb_valid` clears when `wb_ready` is high and there is no `wb_adv`.
- While `iss_v` is 0:
  - `alu_rd_en` = 0.
  - `alu_inputs` holds its last value; it is not zeroed.
- The block does not inspect or modify `alu_inputs_t` fields. It is pure transport.
- Requesters must hold payload stable while valid and not ready. Dropping valid without a handshake is legal.

## Timing
- Reset values: `iss_v`=0, `wb_valid`=0, `busy`=0, `alu_rd_en`=0, `req_ready`=0, RR pointer=`NUM_REQ-1`. Payload registers are don't-care.
- Latency: handshake in cycle N → ALU driven in N+1 → `wb_valid` in N+2.
- Throughput is 1 op/cycle when `wb_ready` is held high.
- Full pipe with `wb_ready`=0: `req_ready` is all 0, and both registers hold bit-exact.
- `wb_ready`=1 on a full pipe: WB drains, ISSUE advances and a new grant occurs, all in the same cycle. There are no bubbles.
- Reset asserted mid-operation: both stages are discarded with no writeback, and the pointer is reinitialised.
- `req_valid` arriving in the same cycle as reset is ignored.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - Priority starts at (pointer+1) mod `NUM_REQ`, with wrap-around.
  - The pointer updates to the granted index only on a completed handshake.
  - A valid but unaccepted grant does not move the pointer.
- `ALU_ARB_RR_EN` undefined: fixed priority, lowest index wins. The pointer register is absent.

## Structure
- Add to `riscv_types`:
  - constant `ALU_ARB_MAX_REQ` = 8.
  - typedef `alu_arb_src_t`, logic[2:0].
  - packed struct `alu_issue_t` containing `alu_inputs_t`, `rd_en`, `rd_addr` and `src`. It is reused for the ISSUE and WB registers.
- `alu_inputs_t`, `rs_addr_t` and `XLEN` come from `riscv_types`.
- One sub-module: `alu_rr_arbiter`.
  - Inputs: request vector, `advance`.
  - Output: one-hot `grant`.
  - It contains the pointer and the macro-dependent logic.

## Test plan
- Single requester: `req_valid[0]` with ADD 5+7 and `wb_ready`=1 → `wb_valid` two cycles later with `wb_data`=12, `wb_src`=0, `wb_id` echoed.
- Both requesters continuously valid with `ALU_ARB_RR_EN`: grants alternate 0,1,0,1 over 8 cycles, and `wb_src` alternates accordingly.
- Both valid without the macro: four consecutive grants to 0; requester 1 is granted only after `req_valid[0]` drops.
- `wb_ready`=0 for 5 cycles after two accepts: `req_ready` stays 0, and WB and ISSUE hold. After release, results appear on consecutive cycles in order.
- Reset asserted with both stages full: next cycle `wb_valid`=0, `busy`=0, and no stale writeback afterwards. The first post-reset grant goes to requester 0.
- Back-to-back SUB 3−5 then SLT 3<5 with `wb_ready` toggling 1,0,1: data equals 0xFFFFFFFE then 1. No duplicates and no losses.
